// File: rtl/jtbubl_shared_arb.sv
// jtbubl_shared_arb
// Shares one single-port synchronous RAM between two CPUs. Requester A is
// the main Z80, requester B is the sub Z80 (or MCU). A CPU that is not
// being served is held off through its wait_n line. Read data is returned
// on a registered output that keeps its value until the next access by
// the same requester.
//
// Optional build macro: JTBUBL_SHARED_ARB_RR_EN
//   defined   : simultaneous requests are granted round-robin
//   undefined : requester A always wins simultaneous requests
//
// Ports
//   rst             asynchronous reset, active-high
//   clk24           system clock
//   x_cs            access request (level), x = a or b
//   x_we            write strobe, sampled at grant
//   x_addr, x_din   address / write data, sampled at grant
//   x_dout          registered read data
//   x_wait_n        low while the request is pending (combinational)
//   ram_addr        registered RAM address
//   ram_din         registered RAM write data
//   ram_we          RAM write enable, one-cycle pulse
//   ram_dout        RAM read data, valid one clk24 after ram_addr
module jtbubl_shared_arb #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          rst,
  input  logic          clk24,
  input  logic          a_cs,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  output logic          a_wait_n,
  input  logic          b_cs,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout,
  output logic          b_wait_n,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_CAP  = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nx_s;

  logic owner_r;      // 1'b0 = A, 1'b1 = B
  logic rr_last_r;    // last requester served, 1'b1 = B
  logic served_a_r;
  logic served_b_r;
  logic pend_a_s;
  logic pend_b_s;
  logic grant_s;
  logic cap_s;
  logic win_b_s;

  // A request is pending until its access completes; it re-arms only once cs drops
  assign pend_a_s = a_cs & ~served_a_r;
  assign pend_b_s = b_cs & ~served_b_r;
  assign a_wait_n = ~pend_a_s;
  assign b_wait_n = ~pend_b_s;

  // Winner selection among pending requesters
  always_comb begin
    win_b_s = 1'b0;
    if (pend_a_s && pend_b_s) begin
`ifdef JTBUBL_SHARED_ARB_RR_EN
      // Grant whoever was not served last
      win_b_s = ~rr_last_r;
`else
      // Fixed priority to A; the pointer is kept live so both builds carry the same state
      win_b_s = rr_last_r & 1'b0;
`endif
    end else if (pend_b_s) begin
      win_b_s = 1'b1;
    end else begin
      win_b_s = 1'b0;
    end
  end

  // Next-state and control strobes
  always_comb begin
    state_nx_s = state_r;
    grant_s    = 1'b0;
    cap_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pend_a_s || pend_b_s) begin
          grant_s    = 1'b1;
          state_nx_s = ST_ACC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        state_nx_s = ST_CAP;
      end
      ST_CAP: begin
        cap_s      = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // RAM request registers, read-data capture and round-robin pointer
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      ram_addr  <= {AW{1'b0}};
      ram_din   <= {DW{1'b0}};
      ram_we    <= 1'b0;
      owner_r   <= 1'b0;
      rr_last_r <= 1'b1;
      a_dout    <= {DW{1'b0}};
      b_dout    <= {DW{1'b0}};
    end else begin
      ram_we <= 1'b0;
      if (grant_s) begin
        owner_r  <= win_b_s;
        ram_addr <= win_b_s ? b_addr : a_addr;
        ram_din  <= win_b_s ? b_din  : a_din;
        ram_we   <= win_b_s ? b_we   : a_we;
      end
      if (cap_s) begin
        // Writes also capture whatever the RAM returns; the CPU ignores it
        if (owner_r) begin
          b_dout <= ram_dout;
        end else begin
          a_dout <= ram_dout;
        end
        rr_last_r <= owner_r;
      end
    end
  end

  // Served flags: cleared whenever cs is low (wins over set), set on completion
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      served_a_r <= 1'b0;
      served_b_r <= 1'b0;
    end else begin
      if (!a_cs) begin
        served_a_r <= 1'b0;
      end else if (cap_s && !owner_r) begin
        served_a_r <= 1'b1;
      end
      if (!b_cs) begin
        served_b_r <= 1'b0;
      end else if (cap_s && owner_r) begin
        served_b_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtbubl_shared_arb.sv
// Testbench for jtbubl_shared_arb: directed accesses, a RAM model, and
// scoreboard monitors that check read data, access latency and RAM writes.
module tb_jtbubl_shared_arb;

  logic        rst;
  logic        clk24;
  logic        a_cs, a_we, b_cs, b_we;
  logic [12:0] a_addr, b_addr;
  logic [7:0]  a_din, b_din, a_dout, b_dout;
  logic        a_wait_n, b_wait_n;
  logic [12:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  jtbubl_shared_arb #(.AW(13), .DW(8)) dut (
    .rst(rst), .clk24(clk24),
    .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_wait_n(a_wait_n),
    .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout), .b_wait_n(b_wait_n),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  typedef struct {
    logic [7:0] data;
    bit         chk_d;
    int         lat;
  } exp_t;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  wr_t  exp_w[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // RAM model with a bench-side preload port
  logic [7:0]  mem [0:8191];
  logic        pl_en;
  logic [12:0] pl_addr;
  logic [7:0]  pl_data;

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  always @(posedge clk24) cyc <= cyc + 1;

  always @(posedge clk24) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  task automatic push_a(input logic [7:0] d, input bit c, input int l);
    exp_t e;
    e.data = d; e.chk_d = c; e.lat = l;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] d, input bit c, input int l);
    exp_t e;
    e.data = d; e.chk_d = c; e.lat = l;
    exp_b.push_back(e);
  endtask

  task automatic push_w(input logic [12:0] ad, input logic [7:0] d);
    wr_t w;
    w.addr = ad; w.data = d;
    exp_w.push_back(w);
  endtask

  // Monitor A: on completion compare latency and read data
  logic a_prev, a_busy;
  int   a_start;
  always @(negedge clk24) begin
    if (rst) begin
      a_prev <= 1'b0;
      a_busy <= 1'b0;
    end else begin
      if (a_cs && !a_prev) begin
        a_busy  <= 1'b1;
        a_start <= cyc;
      end else if (a_busy && !a_cs) begin
        a_busy <= 1'b0;
      end else if (a_busy && a_wait_n) begin
        a_busy <= 1'b0;
        if (exp_a.size() == 0) begin
          fail_now("a_unexpected_completion");
        end else begin
          chk("a_latency", cyc - a_start, exp_a[0].lat);
          if (exp_a[0].chk_d) chk("a_dout", {24'b0, a_dout}, {24'b0, exp_a[0].data});
          void'(exp_a.pop_front());
        end
      end
      a_prev <= a_cs;
    end
  end

  // Monitor B: on completion compare latency and read data
  logic b_prev, b_busy;
  int   b_start;
  always @(negedge clk24) begin
    if (rst) begin
      b_prev <= 1'b0;
      b_busy <= 1'b0;
    end else begin
      if (b_cs && !b_prev) begin
        b_busy  <= 1'b1;
        b_start <= cyc;
      end else if (b_busy && !b_cs) begin
        b_busy <= 1'b0;
      end else if (b_busy && b_wait_n) begin
        b_busy <= 1'b0;
        if (exp_b.size() == 0) begin
          fail_now("b_unexpected_completion");
        end else begin
          chk("b_latency", cyc - b_start, exp_b[0].lat);
          if (exp_b[0].chk_d) chk("b_dout", {24'b0, b_dout}, {24'b0, exp_b[0].data});
          void'(exp_b.pop_front());
        end
      end
      b_prev <= b_cs;
    end
  end

  // Write monitor: every ram_we pulse must match the next expected write
  always @(negedge clk24) begin
    if (!rst && ram_we) begin
      if (exp_w.size() == 0) begin
        fail_now("unexpected_ram_we");
      end else begin
        chk("wr_addr", {19'b0, ram_addr}, {19'b0, exp_w[0].addr});
        chk("wr_data", {24'b0, ram_din}, {24'b0, exp_w[0].data});
        void'(exp_w.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk24);
      #1;
    end
  endtask

  task automatic preload(input logic [12:0] ad, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = ad; pl_data = d;
    tick(1);
    pl_en = 1'b0;
  endtask

  // Wait (bounded) until neither requester is stalled, then drop both requests
  task automatic finish_acc();
    int k;
    k = 0;
    @(negedge clk24);
    while (!(a_wait_n && b_wait_n) && k < 20) begin
      @(negedge clk24);
      k++;
    end
    chk("release_timeout", {31'b0, a_wait_n & b_wait_n}, 32'd1);
    tick(1);
    a_cs = 1'b0; b_cs = 1'b0; a_we = 1'b0; b_we = 1'b0;
    tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_cs = 1'b0; a_we = 1'b0; a_addr = 13'h0; a_din = 8'h0;
    b_cs = 1'b0; b_we = 1'b0; b_addr = 13'h0; b_din = 8'h0;
    pl_en = 1'b0; pl_addr = 13'h0; pl_data = 8'h0;
    tick(1);
    preload(13'h0123, 8'h5A);
    preload(13'h0010, 8'h11);
    preload(13'h0020, 8'h22);

    // Reset state
    chk("rst_ram_we",   {31'b0, ram_we}, 32'd0);
    chk("rst_ram_addr", {19'b0, ram_addr}, 32'd0);
    chk("rst_ram_din",  {24'b0, ram_din}, 32'd0);
    chk("rst_a_dout",   {24'b0, a_dout}, 32'd0);
    chk("rst_b_dout",   {24'b0, b_dout}, 32'd0);
    chk("rst_a_wait_n", {31'b0, a_wait_n}, 32'd1);
    chk("rst_b_wait_n", {31'b0, b_wait_n}, 32'd1);
    rst = 1'b0;
    while (cyc < 10) tick(1);

    // Single read by A at cycle 10
    a_addr = 13'h0123; a_we = 1'b0; a_cs = 1'b1;
    push_a(8'h5A, 1'b1, 3);
    finish_acc();

    // Single write by B, then read back by A and B
    b_addr = 13'h1FFF; b_din = 8'hC3; b_we = 1'b1; b_cs = 1'b1;
    push_b(8'h00, 1'b0, 3);
    push_w(13'h1FFF, 8'hC3);
    finish_acc();
    a_addr = 13'h1FFF; a_cs = 1'b1;
    push_a(8'hC3, 1'b1, 3);
    finish_acc();
    b_addr = 13'h1FFF; b_cs = 1'b1;
    push_b(8'hC3, 1'b1, 3);
    finish_acc();

    // Simultaneous reads after a B access: A first in both builds
    a_addr = 13'h0010; b_addr = 13'h0020; a_cs = 1'b1; b_cs = 1'b1;
    push_a(8'h11, 1'b1, 3);
    push_b(8'h22, 1'b1, 6);
    finish_acc();
    chk("hold_a_dout", {24'b0, a_dout}, 32'h11);

    // A access so the last served requester is A; B output must hold
    a_addr = 13'h0123; a_cs = 1'b1;
    push_a(8'h5A, 1'b1, 3);
    finish_acc();
    chk("hold_b_dout", {24'b0, b_dout}, 32'h22);

    // Second simultaneous pair
    a_addr = 13'h0010; b_addr = 13'h0020; a_cs = 1'b1; b_cs = 1'b1;
`ifdef JTBUBL_SHARED_ARB_RR_EN
    push_b(8'h22, 1'b1, 3);
    push_a(8'h11, 1'b1, 6);
`else
    push_a(8'h11, 1'b1, 3);
    push_b(8'h22, 1'b1, 6);
`endif
    finish_acc();

    // Held cs: one access only; later address changes are ignored
    a_addr = 13'h0123; a_cs = 1'b1;
    push_a(8'h5A, 1'b1, 3);
    tick(4);
    a_addr = 13'h0010;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk("held_a_wait_n", {31'b0, a_wait_n}, 32'd1);
    end
    chk("held_ram_addr", {19'b0, ram_addr}, 32'h0123);
    a_cs = 1'b0;
    tick(2);

    // Abort: B drops cs during ACC of a write; the write still lands
    b_addr = 13'h0400; b_din = 8'h77; b_we = 1'b1; b_cs = 1'b1;
    push_w(13'h0400, 8'h77);
    tick(1);
    b_cs = 1'b0; b_we = 1'b0;
    tick(3);
    chk("abort_b_wait_n", {31'b0, b_wait_n}, 32'd1);
    b_addr = 13'h0400; b_cs = 1'b1;
    push_b(8'h77, 1'b1, 3);
    finish_acc();

    // Reset during ACC of an A write: pulse cut, fresh access after release
    a_addr = 13'h0050; a_din = 8'h99; a_we = 1'b1; a_cs = 1'b1;
    tick(1);
    rst = 1'b1;
    #1;
    chk("rst_acc_ram_we",   {31'b0, ram_we}, 32'd0);
    chk("rst_acc_ram_addr", {19'b0, ram_addr}, 32'd0);
    chk("rst_acc_a_dout",   {24'b0, a_dout}, 32'd0);
    tick(1);
    push_w(13'h0050, 8'h99);
    push_a(8'h00, 1'b0, 3);
    rst = 1'b0;
    #1;
    chk("rst_rel_a_wait_n", {31'b0, a_wait_n}, {31'b0, ~a_cs});
    finish_acc();
    a_addr = 13'h0050; a_we = 1'b0; a_cs = 1'b1;
    push_a(8'h99, 1'b1, 3);
    finish_acc();

    tick(2);
    chk("exp_a_left", exp_a.size(), 32'd0);
    chk("exp_b_left", exp_b.size(), 32'd0);
    chk("exp_w_left", exp_w.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
